// File: rtl/ar_tag_allocator_if.sv
// AXI AR channel bundle: receiver modport consumes a request, sender modport produces one.
interface ar_if #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SIZE_WIDTH  = 3,
  parameter int unsigned BURST_WIDTH = 2,
  parameter int unsigned QOS_WIDTH   = 4
);
  logic                   valid;
  logic                   ready;
  logic [ID_WIDTH-1:0]    id;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   len;
  logic [SIZE_WIDTH-1:0]  size;
  logic [BURST_WIDTH-1:0] burst;
  logic [QOS_WIDTH-1:0]   qos;

  modport receiver (input valid, id, addr, len, size, burst, qos, output ready);
  modport sender   (output valid, id, addr, len, size, burst, qos, input ready);
endinterface

// File: rtl/ar_tag_allocator.sv
// Swaps each incoming AR id for a free internal tag, remembers the original id/len per tag,
// and holds tags busy until the response side releases them.
module ar_tag_allocator #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SIZE_WIDTH  = 3,
  parameter int unsigned BURST_WIDTH = 2,
  parameter int unsigned QOS_WIDTH   = 4,
  parameter int unsigned NUM_TAGS    = 8,
  localparam int unsigned TAG_W      = (NUM_TAGS <= 2) ? 1 : $clog2(NUM_TAGS),
  localparam int unsigned CNT_W      = $clog2(NUM_TAGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ar_if.receiver               ar_in,
  ar_if.sender                 ar_out,
  input  logic                 rel_valid,
  input  logic [TAG_W-1:0]     rel_tag,
  input  logic [TAG_W-1:0]     lut_tag,
  output logic [ID_WIDTH-1:0]  lut_orig_id,
  output logic [LEN_WIDTH-1:0] lut_len,
  output logic                 lut_busy,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 full
);

  logic [NUM_TAGS-1:0]    r_busy;
  logic [ID_WIDTH-1:0]    r_orig_id [NUM_TAGS];
  logic [LEN_WIDTH-1:0]   r_len     [NUM_TAGS];
  logic [CNT_W-1:0]       r_cnt;

  logic                   r_out_valid;
  logic [ID_WIDTH-1:0]    r_out_id;
  logic [ADDR_WIDTH-1:0]  r_out_addr;
  logic [LEN_WIDTH-1:0]   r_out_len;
  logic [SIZE_WIDTH-1:0]  r_out_size;
  logic [BURST_WIDTH-1:0] r_out_burst;
  logic [QOS_WIDTH-1:0]   r_out_qos;

  logic [TAG_W-1:0]       w_alloc_tag;
  logic                   w_any_free;
  logic                   w_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_rel_eff;
  logic [NUM_TAGS-1:0]    w_push_mask;
  logic [NUM_TAGS-1:0]    w_rel_mask;

  // Lowest-index free tag; scanning downward lets the last hit win.
  always_comb begin
    w_alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (~r_busy[i]) w_alloc_tag = TAG_W'(i);
    end
  end

  assign w_any_free  = |(~r_busy);
  assign w_ready     = w_any_free & (~r_out_valid | ar_out.ready);
  assign w_push      = ar_in.valid & w_ready;
  assign w_pop       = r_out_valid & ar_out.ready;
  assign w_rel_eff   = rel_valid & r_busy[rel_tag];
  assign w_push_mask = {{(NUM_TAGS-1){1'b0}}, w_push} << w_alloc_tag;
  assign w_rel_mask  = {{(NUM_TAGS-1){1'b0}}, w_rel_eff} << rel_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_rel_mask) | w_push_mask;
      case ({w_push, w_rel_eff})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Per-tag record table; contents are meaningless while a tag is free.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_orig_id[w_alloc_tag] <= ar_in.id;
      r_len[w_alloc_tag]     <= ar_in.len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_addr  <= '0;
      r_out_len   <= '0;
      r_out_size  <= '0;
      r_out_burst <= '0;
      r_out_qos   <= '0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_out_id    <= ID_WIDTH'(w_alloc_tag);
      r_out_addr  <= ar_in.addr;
      r_out_len   <= ar_in.len;
      r_out_size  <= ar_in.size;
      r_out_burst <= ar_in.burst;
      r_out_qos   <= ar_in.qos;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign ar_in.ready  = w_ready;
  assign ar_out.valid = r_out_valid;
  assign ar_out.id    = r_out_id;
  assign ar_out.addr  = r_out_addr;
  assign ar_out.len   = r_out_len;
  assign ar_out.size  = r_out_size;
  assign ar_out.burst = r_out_burst;
  assign ar_out.qos   = r_out_qos;

  assign lut_orig_id = r_orig_id[lut_tag];
  assign lut_len     = r_len[lut_tag];
  assign lut_busy    = r_busy[lut_tag];
  assign outstanding = r_cnt;
  assign full        = &r_busy;

endmodule

// File: tb/tb_ar_tag_allocator.sv
// Scenario bench for ar_tag_allocator with a scoreboard of expected ar_out beats.
module tb_ar_tag_allocator;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  qos;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rel_valid;
  logic [2:0] rel_tag;
  logic [2:0] lut_tag;
  logic [3:0] lut_orig_id;
  logic [7:0] lut_len;
  logic       lut_busy;
  logic [3:0] outstanding;
  logic       full;

  int errors = 0;
  int checks = 0;

  exp_t       sbq[$];
  exp_t       m_exp;
  exp_t       m_got;
  logic [7:0] m_busy;
  logic [2:0] m_tag;

  ar_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
          .BURST_WIDTH(2), .QOS_WIDTH(4)) u_in ();
  ar_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
          .BURST_WIDTH(2), .QOS_WIDTH(4)) u_out ();

  ar_tag_allocator #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
                     .BURST_WIDTH(2), .QOS_WIDTH(4), .NUM_TAGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(u_in.receiver), .ar_out(u_out.sender),
    .rel_valid(rel_valid), .rel_tag(rel_tag), .lut_tag(lut_tag),
    .lut_orig_id(lut_orig_id), .lut_len(lut_len), .lut_busy(lut_busy),
    .outstanding(outstanding), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare departing beats, queue expected beats for accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_busy = '0;
    end else begin
      if (u_out.valid & u_out.ready) begin
        checks++;
        m_got = '{u_out.id, u_out.addr, u_out.len, u_out.size, u_out.burst, u_out.qos};
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: unexpected beat got=%h expected none", m_got);
        end else begin
          m_exp = sbq.pop_front();
          if (m_got !== m_exp) begin
            errors++;
            $display("FAIL sb_beat: got=%h expected=%h", m_got, m_exp);
          end
        end
      end
      m_tag = '0;
      for (int i = 7; i >= 0; i--) if (!m_busy[i]) m_tag = 3'(i);
      if (rel_valid & m_busy[rel_tag]) m_busy[rel_tag] = 1'b0;
      if (u_in.valid & u_in.ready) begin
        sbq.push_back('{{1'b0, m_tag}, u_in.addr, u_in.len, u_in.size, u_in.burst, u_in.qos});
        m_busy[m_tag] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_ar(input logic v, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    u_in.valid = v;
    u_in.id    = id;
    u_in.addr  = addr;
    u_in.len   = len;
    u_in.size  = 3'(len[1:0]);
    u_in.burst = 2'd1;
    u_in.qos   = id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rel_valid = 1'b0; rel_tag = '0; lut_tag = '0;
    u_out.ready = 1'b0;
    set_ar(1'b0, 4'd0, 32'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (u_out.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got=%b exp=0", u_out.valid); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outstanding: got=%0d exp=0", outstanding); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got=%b exp=0", full); end
    checks++; if (lut_busy !== 1'b0) begin errors++; $display("FAIL rst_lut_busy: got=%b exp=0", lut_busy); end
    checks++; if (u_out.addr !== 32'd0 || u_out.id !== 4'd0) begin errors++; $display("FAIL rst_fields: addr=%h id=%0d exp 0", u_out.addr, u_out.id); end
    checks++; if (u_in.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got=%b exp=1", u_in.ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    u_out.ready = 1'b1;
    lut_tag = 3'd0;
    set_ar(1'b1, 4'd5, 32'h1000, 8'd3);
    at_neg();
    checks++; if (u_in.ready !== 1'b1) begin errors++; $display("FAIL single_ready: got=%b exp=1", u_in.ready); end
    tick();
    u_in.valid = 1'b0;
    at_neg();
    checks++; if (u_out.valid !== 1'b1 || u_out.id !== 4'd0) begin errors++; $display("FAIL single_out: valid=%b id=%0d exp 1/0", u_out.valid, u_out.id); end
    checks++; if (u_out.addr !== 32'h1000 || u_out.len !== 8'd3) begin errors++; $display("FAIL single_fields: addr=%h len=%0d exp 1000/3", u_out.addr, u_out.len); end
    checks++; if (lut_orig_id !== 4'd5 || lut_len !== 8'd3 || lut_busy !== 1'b1) begin errors++; $display("FAIL single_lut: id=%0d len=%0d busy=%b exp 5/3/1", lut_orig_id, lut_len, lut_busy); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_outstanding: got=%0d exp=1", outstanding); end
    tick();
    rel_valid = 1'b1; rel_tag = 3'd0;
    tick();
    rel_valid = 1'b0;
    at_neg();
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_release: got=%0d exp=0", outstanding); end
    tick();
  endtask

  task automatic test_back_to_back();
    u_out.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ar(1'b1, 4'(15 - i), 32'h2000 + 32'(i * 64), 8'(i));
      at_neg();
      checks++; if (u_in.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got=%b exp=1", i, u_in.ready); end
      tick();
    end
    set_ar(1'b1, 4'd2, 32'h2F00, 8'd9);
    at_neg();
    checks++; if (u_out.id !== 4'd7) begin errors++; $display("FAIL b2b_last_tag: got=%0d exp=7", u_out.id); end
    checks++; if (full !== 1'b1 || u_in.ready !== 1'b0) begin errors++; $display("FAIL b2b_full: full=%b ready=%b exp 1/0", full, u_in.ready); end
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL b2b_outstanding: got=%0d exp=8", outstanding); end
    tick();
    at_neg();
    checks++; if (u_in.ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: ready=%b exp=0", u_in.ready); end
    tick();
  endtask

  task automatic test_release_full();
    rel_valid = 1'b1; rel_tag = 3'd3;
    at_neg();
    checks++; if (u_in.ready !== 1'b0) begin errors++; $display("FAIL relfull_same_cycle: ready=%b exp=0", u_in.ready); end
    tick();
    rel_valid = 1'b0;
    at_neg();
    checks++; if (u_in.ready !== 1'b1 || full !== 1'b0 || outstanding !== 4'd7) begin errors++; $display("FAIL relfull_next: ready=%b full=%b cnt=%0d exp 1/0/7", u_in.ready, full, outstanding); end
    tick();
    u_in.valid = 1'b0;
    at_neg();
    checks++; if (u_out.valid !== 1'b1 || u_out.id !== 4'd3 || u_out.addr !== 32'h2F00) begin errors++; $display("FAIL relfull_tag: valid=%b id=%0d addr=%h exp 1/3/2f00", u_out.valid, u_out.id, u_out.addr); end
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL relfull_outstanding: got=%0d exp=8", outstanding); end
    tick();
    for (int t = 0; t < 8; t++) begin
      rel_valid = 1'b1; rel_tag = 3'(t);
      tick();
    end
    rel_valid = 1'b0;
    at_neg();
    checks++; if (outstanding !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL relfull_drain: cnt=%0d full=%b exp 0/0", outstanding, full); end
    tick();
  endtask

  task automatic test_backpressure();
    u_out.ready = 1'b0;
    set_ar(1'b1, 4'd9, 32'h3000, 8'd5);
    tick();
    set_ar(1'b1, 4'd10, 32'h4000, 8'd6);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      checks++;
      if (u_in.ready !== 1'b0 || u_out.valid !== 1'b1 || u_out.addr !== 32'h3000 || u_out.id !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ready=%b valid=%b addr=%h id=%0d exp 0/1/3000/0", k, u_in.ready, u_out.valid, u_out.addr, u_out.id);
      end
      tick();
    end
    u_out.ready = 1'b1;
    at_neg();
    checks++; if (u_in.ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got=%b exp=1", u_in.ready); end
    tick();
    u_in.valid = 1'b0;
    at_neg();
    checks++; if (u_out.valid !== 1'b1 || u_out.id !== 4'd1 || u_out.addr !== 32'h4000) begin errors++; $display("FAIL bp_reload: valid=%b id=%0d addr=%h exp 1/1/4000", u_out.valid, u_out.id, u_out.addr); end
    tick();
  endtask

  task automatic test_release_corner();
    lut_tag = 3'd6;
    rel_valid = 1'b1; rel_tag = 3'd6;
    at_neg();
    checks++; if (lut_busy !== 1'b0) begin errors++; $display("FAIL corner_free_busy: got=%b exp=0", lut_busy); end
    tick();
    rel_valid = 1'b0;
    at_neg();
    checks++; if (outstanding !== 4'd2 || lut_busy !== 1'b0) begin errors++; $display("FAIL corner_free_release: cnt=%0d busy=%b exp 2/0", outstanding, lut_busy); end
    tick();
    set_ar(1'b1, 4'd11, 32'h5000, 8'd7);
    rel_valid = 1'b1; rel_tag = 3'd0;
    tick();
    u_in.valid = 1'b0;
    rel_valid = 1'b0;
    lut_tag = 3'd0;
    at_neg();
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL corner_push_rel: cnt=%0d exp=2", outstanding); end
    checks++; if (u_out.id !== 4'd2 || lut_busy !== 1'b0) begin errors++; $display("FAIL corner_tag: id=%0d busy0=%b exp 2/0", u_out.id, lut_busy); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      set_ar(1'b1, 4'(k), 32'h6000 + 32'(k * 16), 8'd1);
      tick();
    end
    u_in.valid = 1'b0;
    u_out.ready = 1'b0;
    at_neg();
    checks++; if (outstanding !== 4'd5 || u_out.valid !== 1'b1) begin errors++; $display("FAIL mid_pre: cnt=%0d valid=%b exp 5/1", outstanding, u_out.valid); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (u_out.valid !== 1'b0 || outstanding !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL mid_async: valid=%b cnt=%0d full=%b exp 0/0/0", u_out.valid, outstanding, full); end
    tick();
    rst_n = 1'b1;
    u_out.ready = 1'b1;
    set_ar(1'b1, 4'd3, 32'h7000, 8'd2);
    at_neg();
    checks++; if (u_in.ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready: got=%b exp=1", u_in.ready); end
    tick();
    u_in.valid = 1'b0;
    at_neg();
    checks++; if (u_out.id !== 4'd0 || outstanding !== 4'd1) begin errors++; $display("FAIL mid_after_tag: id=%0d cnt=%0d exp 0/1", u_out.id, outstanding); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_release_full();
    test_backpressure();
    test_release_corner();
    test_reset_mid();
    at_neg();
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover: got=%0d exp=0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ar_tag_allocator.md
Name: ar_tag_allocator

Overview:
- Sits directly upstream of the outgoing AR request FIFO, between the AXI master-side AR channel and that FIFO.
- Replaces each incoming AR ID with an internal tag drawn from a free pool, and records the original ID and burst length per tag.
- The read-response reorder logic uses those records to restore ordering and the original ID.
- A tag stays busy until the response side releases it after the last R beat.

Parameters:
- ID_WIDTH, 4, width of AR id on both sides; must be >= TAG_W.
- ADDR_WIDTH, 32, AR address width.
- LEN_WIDTH, 8, AR len width.
- SIZE_WIDTH, 3, AR size width.
- BURST_WIDTH, 2, AR burst width.
- QOS_WIDTH, 4, AR qos width.
- NUM_TAGS, 8, number of internal tags (max outstanding reads); TAG_W = (NUM_TAGS<=2) ? 1 : $clog2(NUM_TAGS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ar_in  ar_if.receiver  -  AR from AXI master (valid, ready, id, addr, len, size, burst, qos).
- ar_out  ar_if.sender  -  AR toward the outgoing request FIFO; id carries the tag, zero-extended.
- rel_valid  input  1  release strobe from the response side.
- rel_tag  input  TAG_W  tag to release.
- lut_tag  input  TAG_W  lookup index.
- lut_orig_id  output  ID_WIDTH  original ID stored for lut_tag (combinational).
- lut_len  output  LEN_WIDTH  len stored for lut_tag (combinational).
- lut_busy  output  1  tag lut_tag currently allocated.
- outstanding  output  $clog2(NUM_TAGS+1)  count of allocated tags.
- full  output  1  no free tag.

Behaviour:
- State:
  - busy[NUM_TAGS] bit vector.
  - Table orig_id[], len[] per tag.
  - Single output register stage (out_valid_q plus registered AR fields).
  - outstanding counter.
- Reset (rst_n=0, async):
  - busy all 0, outstanding=0, out_valid_q=0, full=0.
  - ar_out.valid=0; ar_out fields all 0.
  - Table contents don't-care; lut_busy reflects busy.
- Free/full:
  - free = ~busy.
  - full = (busy all 1), equivalently outstanding==NUM_TAGS.
- Accept rule:
  - ar_in.ready = (|free) & (~out_valid_q | ar_out.ready).
  - push = ar_in.valid & ar_in.ready.
- Allocation:
  - On push, pick the lowest-index free tag, computed from pre-edge busy.
  - Set busy[tag], store orig_id=ar_in.id and len=ar_in.len.
  - Load the output register: ar_out.id = tag zero-extended to ID_WIDTH; addr/len/size/burst/qos copied unchanged.
  - out_valid_q=1.
- Latency: exactly 1 cycle from ar_in handshake to ar_out.valid.
- Output handshake:
  - ar_out.valid = out_valid_q.
  - Fields held stable while valid & ~ready.
  - pop = valid & ready.
  - On pop without push, out_valid_q clears.
  - On pop with push, the register reloads (full throughput, one AR per cycle).
- Release:
  - rel_valid with busy[rel_tag]=1 clears busy[rel_tag] at the edge.
  - rel_valid on a tag not busy is ignored; outstanding is unchanged.
  - A released tag is not allocatable in the same cycle. Allocation sees pre-edge busy, so when full, a same-cycle release leaves ready=0 that cycle, and the tag is usable the next cycle.
- Counter:
  - +1 on push only.
  - -1 on effective release only.
  - Unchanged when both happen or neither.
  - Never exceeds NUM_TAGS; never underflows.
- Lookup: lut_orig_id, lut_len, lut_busy are purely combinational from the table/busy at lut_tag.
- Reset mid-operation: all tags freed and any pending ar_out beat dropped immediately (valid deasserts asynchronously).
- Control logic uses bitwise operators only.

Test Plan:
- Reset then single AR (id=5, addr=0x1000, len=3) -> next cycle ar_out.valid=1, id=0, addr=0x1000, len=3; lut_tag=0 gives orig_id=5, len=3, busy=1; outstanding=1.
- Eight back-to-back ARs with ar_out.ready=1 -> tags 0..7 in order, one per cycle; then full=1, ar_in.ready=0, and the 9th AR stalls.
- Full, then rel_valid with rel_tag=3 -> ready stays 0 in the release cycle, goes to 1 the next cycle; the next AR gets tag 3, and outstanding returns to 8.
- ar_out.ready=0 for 4 cycles with a pending beat and another ar_in.valid -> ar_out fields stable, ar_in.ready=0; on ready=1 the pending beat pops and the new AR loads the same cycle.
- rel_valid on a free tag 6 -> busy and outstanding unchanged. Same-cycle push plus valid release -> outstanding unchanged.
- Assert rst_n=0 with 5 tags busy and ar_out.valid=1 -> ar_out.valid=0 and outstanding=0 immediately; after reset the first AR gets tag 0.
